load_unit: RTL and testbench
============================

# load_unit

Byte-serial load engine for the memory stage: the read-side counterpart of the store path into the byte-addressed data memory. Accepts one load request (address from the ALU, load type from decode, destination register) per transaction. Reads the required bytes from the 8-bit-wide memory array one per cycle, assembles them little-endian and sign- or zero-extends the result. Hands a 32-bit value to writeback over a valid/ready handshake.

## Interface

- MEM_DEPTH, 1024: number of bytes in the data memory; valid byte addresses are 0..MEM_DEPTH-1.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  32  byte address from ALU.
- req_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_rd  in  5  destination register index.
- mem_addr  out  32  byte address to data memory.
- mem_rd_en  out  1  read strobe, high in READ only.
- mem_rd_data  in  8  byte from memory, combinational from mem_addr.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts result.
- resp_data  out  32  extended load result.
- resp_rd  out  5  latched req_rd.
- resp_error  out  1  misaligned, out-of-range or illegal funct3.

## Operation

- States: IDLE, READ, DONE.
- IDLE: req_ready=1. On req_valid, latch addr, funct3 and rd. Clear the assembly register and byte index.
  - Byte count N: 1 for LB/LBU, 2 for LH/LHU, 4 for LW.
  - Error check at accept: funct3 not in the legal set, or addr not N-aligned (LH/LHU addr[0]≠0; LW addr[1:0]≠0), or addr+N-1 > MEM_DEPTH-1.
  - The range check uses a 33-bit sum so that 32-bit wrap cannot pass.
  - Error → DONE with resp_error=1, resp_data=0.
  - No error → READ.
- READ: mem_rd_en=1, mem_addr=base+idx.
  - Each cycle writes mem_rd_data into byte lane idx of the assembly register (lane 0 = bits 7:0) and increments idx.
  - When idx==N-1 is captured → DONE.
- DONE: resp_valid=1 and resp_data held stable.
  - LB/LH replicate bit 7/15 into the upper bits; LBU/LHU zero-fill; LW passes through.
  - Hold DONE until resp_ready=1, then return to IDLE.
- mem_addr=0 and mem_rd_en=0 outside READ. The unit never writes memory.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, resp_error=0, mem_rd_en=0, mem_addr=0, idx=0.
- Accept at edge T (req_valid&req_ready sampled high). READ occupies cycles T+1..T+N. resp_valid rises in cycle T+N+1.
  - Latency: LB/LBU 2 cycles, LH/LHU 3 cycles, LW 5 cycles from accept to resp_valid.
- Error path: resp_valid rises in cycle T+1; no READ cycles; mem_rd_en never asserts.
- Response handshake completes on the edge where resp_valid&resp_ready.
  - The unit is in IDLE the next cycle, so req_ready=1 there; there is no same-cycle accept from DONE.
  - Back-to-back loads have at least one idle cycle between resp and the next accept.
- resp_ready held low: all resp_* outputs stay unchanged indefinitely.
- resp_ready high before DONE is ignored.
- req_valid outside IDLE is ignored (req_ready=0); the request fields need only be stable in the accept cycle.
- reset asserted in any state, including mid-READ or DONE with resp_valid high: the next cycle shows reset values. The in-flight load is discarded with no response.
- Boundary addresses:
  - LW at MEM_DEPTH-4 is legal and reads bytes MEM_DEPTH-4..MEM_DEPTH-1.
  - LB at MEM_DEPTH-1 is legal.
  - LB at MEM_DEPTH is an error.
  - addr 0xFFFF_FFFC with LW is an error.

## Test plan

- Preload mem[0x10..0x13]=0x78,0x56,0x34,0x12; LW 0x10, resp_ready=1 → resp_valid exactly 5 cycles after accept, resp_data=0x12345678, resp_error=0, mem_addr sequence 0x10,0x11,0x12,0x13.
- mem[0x20]=0x80; LB 0x20 → 0xFFFFFF80; LBU 0x20 → 0x00000080; each valid 2 cycles after accept. mem[0x22..0x23]=0x01,0x90: LH 0x22 → 0xFFFF9001; LHU → 0x00009001.
- LW 0x11, LH 0x23, funct3=011 at 0x0, LW 0x3FE with MEM_DEPTH=1024 → each gives resp_valid one cycle after accept, resp_error=1, resp_data=0, mem_rd_en never high. LW 0x3FC → no error.
- LW 0x10 with resp_ready low for 6 cycles after resp_valid → outputs constant and req_ready=0 throughout; on resp_ready=1, IDLE next cycle; a second request with req_rd=7 is accepted and returns resp_rd=7.
- Reset pulse during the 2nd READ cycle of an LW → next cycle: all outputs at reset values. No resp_valid for that load. A following LB returns correct data.
- Random loop of 200 legal/illegal loads with a random resp_ready stall → results match a reference byte-array model, and the latency rule holds for every transaction.

Source files
------------

// File: rtl/load_unit_if.sv
// Request, data-memory read and response signals of the load unit.
// The load unit itself uses the master modport; the surrounding pipeline/memory uses slave.
interface load_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_error;

  modport master (
    input  req_valid, req_addr, req_funct3, req_rd, mem_rd_data, resp_ready,
    output req_ready, mem_addr, mem_rd_en, resp_valid, resp_data, resp_rd, resp_error
  );

  modport slave (
    output req_valid, req_addr, req_funct3, req_rd, mem_rd_data, resp_ready,
    input  req_ready, mem_addr, mem_rd_en, resp_valid, resp_data, resp_rd, resp_error
  );
endinterface

// File: rtl/load_unit.sv
// Byte-serial load engine: reads 1/2/4 bytes from an 8-bit memory, assembles them
// little-endian, extends per load type and returns the word over valid/ready.
module load_unit #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic reset,
  load_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [1:0]  r_idx;
  logic [1:0]  r_last;
  logic [31:0] r_asm;
  logic        r_req_ready;
  logic [31:0] r_mem_addr;
  logic        r_mem_rd_en;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_error;

  logic [1:0]  w_last_idx;
  logic        w_legal;
  logic        w_misaligned;
  logic [32:0] w_end_addr;
  logic        w_out_of_range;
  logic        w_err;
  logic [31:0] w_merged;
  logic [31:0] w_ext;

  always_comb begin
    w_last_idx = 2'd3;
    case (bus.req_funct3[1:0])
      2'b00:   w_last_idx = 2'd0;
      2'b01:   w_last_idx = 2'd1;
      default: w_last_idx = 2'd3;
    endcase
  end

  assign w_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  // 33-bit end address so that a request near 0xFFFF_FFFF cannot wrap into range.
  assign w_end_addr     = {1'b0, bus.req_addr} + {31'd0, w_last_idx};
  assign w_out_of_range = w_end_addr > 33'(MEM_DEPTH - 1);
  assign w_err          = !w_legal || w_misaligned || w_out_of_range;

  // Assembly register with the incoming byte dropped into lane r_idx.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[8*gi +: 8] = (r_idx == 2'(gi)) ? bus.mem_rd_data : r_asm[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_ext = w_merged;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_merged[7]}}, w_merged[7:0]};
      3'b001:  w_ext = {{16{w_merged[15]}}, w_merged[15:0]};
      3'b100:  w_ext = {24'd0, w_merged[7:0]};
      3'b101:  w_ext = {16'd0, w_merged[15:0]};
      default: w_ext = w_merged;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_funct3     <= 3'd0;
      r_rd         <= 5'd0;
      r_idx        <= 2'd0;
      r_last       <= 2'd0;
      r_asm        <= 32'd0;
      r_req_ready  <= 1'b1;
      r_mem_addr   <= 32'd0;
      r_mem_rd_en  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_funct3    <= bus.req_funct3;
            r_rd        <= bus.req_rd;
            r_idx       <= 2'd0;
            r_last      <= w_last_idx;
            r_asm       <= 32'd0;
            r_req_ready <= 1'b0;
            if (w_err) begin
              r_state      <= DONE;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_data  <= 32'd0;
            end else begin
              r_state     <= READ;
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= bus.req_addr;
            end
          end
        end
        READ: begin
          r_asm <= w_merged;
          if (r_idx == r_last) begin
            r_state      <= DONE;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
            r_resp_data  <= w_ext;
          end else begin
            r_idx      <= r_idx + 2'd1;
            r_mem_addr <= r_mem_addr + 32'd1;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_rd_en  = r_mem_rd_en;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_rd    = r_rd;
  assign bus.resp_error = r_resp_error;

endmodule

// File: tb/tb_load_unit.sv
// Directed and randomised bench for load_unit against a byte-array reference model.
module tb_load_unit;
  logic clk;
  logic reset;
  logic [7:0] mem [1024];
  int passes;
  int total;

  load_unit_if bus ();

  load_unit #(.MEM_DEPTH(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_rd_data = (bus.mem_addr < 32'd1024) ? mem[bus.mem_addr[9:0]] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req_ready"},  32'(bus.req_ready), 32'd1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " resp_data"},  bus.resp_data, 32'd0);
    check({tag, " resp_rd"},    32'(bus.resp_rd), 32'd0);
    check({tag, " resp_error"}, 32'(bus.resp_error), 32'd0);
    check({tag, " mem_rd_en"},  32'(bus.mem_rd_en), 32'd0);
    check({tag, " mem_addr"},   bus.mem_addr, 32'd0);
  endtask

  // Reference: legality, byte gather and extension computed straight from the array.
  function automatic void ref_load(input logic [31:0] a, input logic [2:0] f,
                                   output logic [31:0] d, output logic e, output int n);
    logic [31:0] v;
    int nb;
    case (f)
      3'b000, 3'b100: nb = 1;
      3'b001, 3'b101: nb = 2;
      3'b010:         nb = 4;
      default:        nb = 0;
    endcase
    if (nb == 0) e = 1'b1;
    else e = ((a % nb) != 0) || (({1'b0, a} + 33'(nb - 1)) > 33'd1023);
    v = 32'd0;
    d = 32'd0;
    n = 0;
    if (!e) begin
      n = nb;
      for (int i = 0; i < nb; i++) v = v | (32'(mem[10'(a + 32'(i))]) << (8 * i));
      case (f)
        3'b000:  d = {{24{v[7]}}, v[7:0]};
        3'b001:  d = {{16{v[15]}}, v[15:0]};
        default: d = v;
      endcase
    end
  endfunction

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f,
                         input logic [4:0] rd, input logic [31:0] exp_d, input logic exp_e,
                         input int exp_n, input int stall, input logic early);
    int lat;
    int rd_cnt;
    int waitc;
    logic seq_ok;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    check({tag, " idle req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_funct3 = f;
    bus.req_rd     = rd;
    bus.resp_ready = early;
    tick();
    // Scramble request fields: the unit must have latched them at accept.
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'hDEAD_BEEF;
    bus.req_funct3 = 3'b011;
    bus.req_rd     = ~rd;
    lat = 1;
    rd_cnt = 0;
    seq_ok = 1'b1;
    while (!bus.resp_valid && lat <= 8) begin
      if (bus.req_ready) seq_ok = 1'b0;
      if (bus.mem_rd_en) begin
        if (bus.mem_addr !== a + 32'(rd_cnt)) seq_ok = 1'b0;
        rd_cnt++;
      end
      tick();
      lat++;
    end
    check({tag, " latency"},    32'(lat), 32'(exp_n + 1));
    check({tag, " read count"}, 32'(rd_cnt), 32'(exp_n));
    check({tag, " addr seq"},   32'(seq_ok), 32'd1);
    check({tag, " resp_data"},  bus.resp_data, exp_d);
    check({tag, " resp_error"}, 32'(bus.resp_error), 32'(exp_e));
    check({tag, " resp_rd"},    32'(bus.resp_rd), 32'(rd));
    check({tag, " done rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    check({tag, " done ready"}, 32'(bus.req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, " stall valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, " stall data"},  bus.resp_data, exp_d);
      check({tag, " stall err"},   32'(bus.resp_error), 32'(exp_e));
      check({tag, " stall rd"},    32'(bus.resp_rd), 32'(rd));
      check({tag, " stall ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, " post valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " post ready"}, 32'(bus.req_ready), 32'd1);
    $display("load %s addr=%h f3=%0d rd=%0d data=%h err=%0d lat=%0d", tag, a, f, rd,
             bus.resp_data, exp_e, lat);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rdat;
    logic [2:0]  rf;
    logic        re;
    int          rn;
    int          rstall;
    logic        rearly;
    passes = 0;
    total  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 5) & 255);
    mem[16'h10] = 8'h78; mem[16'h11] = 8'h56; mem[16'h12] = 8'h34; mem[16'h13] = 8'h12;
    mem[16'h20] = 8'h80; mem[16'h22] = 8'h01; mem[16'h23] = 8'h90;
    mem[16'h3FC] = 8'hDD; mem[16'h3FD] = 8'hCC; mem[16'h3FE] = 8'hBB; mem[16'h3FF] = 8'hAA;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_funct3 = 3'd0;
    bus.req_rd     = 5'd0;
    bus.resp_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("reset");

    do_load("lw10",   32'h10, 3'b010, 5'd1, 32'h12345678, 1'b0, 4, 0, 1'b1);
    do_load("lb20",   32'h20, 3'b000, 5'd2, 32'hFFFFFF80, 1'b0, 1, 0, 1'b0);
    do_load("lbu20",  32'h20, 3'b100, 5'd3, 32'h00000080, 1'b0, 1, 0, 1'b1);
    do_load("lh22",   32'h22, 3'b001, 5'd4, 32'hFFFF9001, 1'b0, 2, 0, 1'b0);
    do_load("lhu22",  32'h22, 3'b101, 5'd5, 32'h00009001, 1'b0, 2, 1, 1'b0);
    do_load("lw11",   32'h11, 3'b010, 5'd6, 32'h0, 1'b1, 0, 0, 1'b0);
    do_load("lh23",   32'h23, 3'b001, 5'd8, 32'h0, 1'b1, 0, 0, 1'b1);
    do_load("f3_011", 32'h0,  3'b011, 5'd9, 32'h0, 1'b1, 0, 0, 1'b0);
    do_load("lw3fe",  32'h3FE, 3'b010, 5'd10, 32'h0, 1'b1, 0, 0, 1'b0);
    do_load("lw3fc",  32'h3FC, 3'b010, 5'd11, 32'hAABBCCDD, 1'b0, 4, 0, 1'b0);
    do_load("lb3ff",  32'h3FF, 3'b000, 5'd12, 32'hFFFFFFAA, 1'b0, 1, 0, 1'b0);
    do_load("lb400",  32'h400, 3'b000, 5'd13, 32'h0, 1'b1, 0, 0, 1'b0);
    do_load("lwwrap", 32'hFFFF_FFFC, 3'b010, 5'd14, 32'h0, 1'b1, 0, 0, 1'b0);
    do_load("lwstall", 32'h10, 3'b010, 5'd15, 32'h12345678, 1'b0, 4, 6, 1'b0);
    do_load("rd7",    32'h13, 3'b100, 5'd7, 32'h00000012, 1'b0, 1, 0, 1'b0);

    // Reset in the second READ cycle of an LW discards the load.
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'b010;
    bus.req_rd     = 5'd20;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("mid-read addr", bus.mem_addr, 32'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("mid-read reset");
    for (int i = 0; i < 4; i++) begin
      check("no resp after reset", 32'(bus.resp_valid), 32'd0);
      tick();
    end
    do_load("lb_after_rst", 32'h20, 3'b000, 5'd21, 32'hFFFFFF80, 1'b0, 1, 0, 1'b0);

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'($urandom_range(0, 1023));
        1: ra = 32'(1024 - $urandom_range(1, 6));
        2: ra = $urandom;
        default: ra = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
      endcase
      rf = 3'($urandom_range(0, 7));
      ref_load(ra, rf, rdat, re, rn);
      rstall = $urandom_range(0, 3);
      rearly = (rstall == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_load($sformatf("rnd%0d", t), ra, rf, 5'($urandom_range(0, 31)), rdat, re, rn,
              rstall, rearly);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit reached");
  end
endmodule
